// File: rtl/onchip_mem_pkg.sv
// Shared defaults and the read-return tag for the on-chip memory arbiter.
// Imported by the arbiter top and its round-robin grant block.
package onchip_mem_pkg;

  localparam int          ADDR_W_DEF   = 14;
  localparam int          DEPTH_DEF    = 12000;
  localparam logic [31:0] OOR_DATA_DEF = 32'hDEAD_BEEF;

  typedef struct packed {
    logic valid;
    logic id;
    logic oor;
  } ret_tag_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with a last-grant register.
// Grants nothing while frozen or held in reset.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       hold,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_gnt;

  always_comb begin
    gnt = 2'b00;
    if (reset_n && !hold) begin
      if (req == 2'b11) gnt = last_gnt ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  last_gnt <= 1'b1;
    else if (|gnt) last_gnt <= gnt[1];
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Two-master arbiter in front of a single-port on-chip RAM with
// one-cycle read latency and out-of-range read/write handling.
module onchip_mem_arbiter
  import onchip_mem_pkg::*;
#(
  parameter int          ADDR_W   = ADDR_W_DEF,
  parameter int          DEPTH    = DEPTH_DEF,
  parameter logic [31:0] OOR_DATA = OOR_DATA_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [3:0]        m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [31:0]       m0_writedata,
  output logic              m0_waitrequest,
  output logic [31:0]       m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [3:0]        m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [31:0]       m1_writedata,
  output logic              m1_waitrequest,
  output logic [31:0]       m1_readdata,
  output logic              m1_readdatavalid,
  input  logic              hold,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic [31:0]       mem_writedata,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata
);

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              sel;
  logic              any;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              wr;
  logic              oor;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  ret_tag_t          tag_q;
  logic [31:0]       rdata;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .hold    (hold),
    .req     (req),
    .gnt     (gnt)
  );

  assign sel = gnt[1];
  assign any = |gnt;

  always_comb begin
    addr  = sel ? m1_address    : m0_address;
    be    = sel ? m1_byteenable : m0_byteenable;
    wdata = sel ? m1_writedata  : m0_writedata;
    wr    = sel ? m1_write      : m0_write;
  end

  assign oor = {{(32-ADDR_W){1'b0}}, addr} >= DEPTH[31:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (any) begin
      addr_q  <= addr;
      be_q    <= be;
      wdata_q <= wdata;
    end
  end

  assign mem_address    = any ? addr  : addr_q;
  assign mem_byteenable = any ? be    : be_q;
  assign mem_writedata  = any ? wdata : wdata_q;
  assign mem_chipselect = any & ~oor;
  assign mem_write      = any & wr & ~oor;
  assign mem_clken      = ~hold;

  assign m0_waitrequest = ~gnt[0];
  assign m1_waitrequest = ~gnt[1];

  // Return tag tracks which master owns next cycle's RAM output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_q <= '0;
    end else begin
      tag_q.valid <= any & ~wr;
      tag_q.id    <= sel;
      tag_q.oor   <= oor;
    end
  end

  assign rdata = tag_q.oor ? OOR_DATA : mem_readdata;

  assign m0_readdatavalid = tag_q.valid & ~tag_q.id;
  assign m1_readdatavalid = tag_q.valid &  tag_q.id;
  assign m0_readdata      = m0_readdatavalid ? rdata : 32'h0;
  assign m1_readdata      = m1_readdatavalid ? rdata : 32'h0;

endmodule
